// File: rtl/cache_pkg.sv
// Shared definitions for the cache and its line-refill engine: default
// geometry, the refill FSM state encoding and the line-offset width helper.
package cache_pkg;

  localparam int DEF_ADDR_WIDTH     = 12;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_WORDS_PER_LINE = 4;

  // Refill FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } refill_state_e;

  // Number of address bits that select a word within a line.
  function automatic int offset_width(input int words_per_line);
    return (words_per_line < 2) ? 1 : $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/refill_addr_gen.sv
// Beat-to-address mapping for a line refill.
// Optional macro CACHE_REFILL_CRITICAL_WORD_FIRST_EN: when defined, the line
// is fetched starting at the requested word and wrapping around the line;
// when undefined, the line is fetched linearly from its base.
module refill_addr_gen
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  localparam int OW            = offset_width(WORDS_PER_LINE)
) (
  input  logic [ADDR_WIDTH-1:0] line_base,
  input  logic [OW-1:0]         crit_off,
  input  logic [OW-1:0]         beat,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic                  is_last,
  output logic                  is_crit
);

  // WORDS_PER_LINE is a power of two, so the last beat is all ones.
  localparam logic [OW-1:0] LAST_BEAT = {OW{1'b1}};

  logic [OW-1:0] word_off_s;

  // Select the word offset within the line for the current beat; the
  // OW-bit add wraps modulo WORDS_PER_LINE by construction.
  always_comb begin
    word_off_s = beat;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    word_off_s = crit_off + beat;
`else
    word_off_s = beat;
`endif
  end

  // line_base has its offset bits cleared, so OR-ing in the offset never
  // carries into the upper address bits (no overflow at the top of memory).
  always_comb begin
    beat_addr = line_base | {{(ADDR_WIDTH-OW){1'b0}}, word_off_s};
    is_last   = (beat == LAST_BEAT);
    is_crit   = (word_off_s == crit_off);
  end

endmodule

// File: rtl/cache_refill_engine.sv
// Cache line refill engine. On a miss it reads the whole line from memory,
// one word per req/ack + valid transaction, writes each word into the cache
// data array, forwards the originally requested word as soon as it arrives
// and pulses fill_done when the line is complete.
// Optional macro CACHE_REFILL_CRITICAL_WORD_FIRST_EN selects critical-word-
// first ordering (handled entirely inside refill_addr_gen).
module cache_refill_engine
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  rsta,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_ack,
  input  logic                  mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  fill_we,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  crit_valid,
  output logic [DATA_WIDTH-1:0] crit_data,
  output logic                  fill_done,
  output logic                  busy
);

  localparam int OW = offset_width(WORDS_PER_LINE);
  localparam logic [OW-1:0] BEAT_ONE = OW'(1'b1);

  refill_state_e         state_r;
  logic [OW-1:0]         beat_r;
  logic [OW-1:0]         crit_off_r;
  logic [ADDR_WIDTH-1:0] line_base_r;

  logic [ADDR_WIDTH-1:0] beat_addr_s;
  logic                  is_last_s;
  logic                  is_crit_s;

  refill_addr_gen #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_addr_gen (
    .line_base(line_base_r),
    .crit_off (crit_off_r),
    .beat     (beat_r),
    .beat_addr(beat_addr_s),
    .is_last  (is_last_s),
    .is_crit  (is_crit_s)
  );

  // Refill sequencing: accept a miss, then alternate request/wait per beat.
  always_ff @(posedge clk) begin
    if (!rsta) begin
      state_r     <= ST_IDLE;
      beat_r      <= '0;
      crit_off_r  <= '0;
      line_base_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (miss_valid) begin
            line_base_r <= {miss_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
            crit_off_r  <= miss_addr[OW-1:0];
            beat_r      <= '0;
            state_r     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Request and address stay put until memory accepts.
          if (mem_rd_ack) begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rd_valid) begin
            if (is_last_s) begin
              state_r <= ST_DONE;
            end else begin
              beat_r  <= beat_r + BEAT_ONE;
              state_r <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from state; fill and critical-word forwarding are
  // combinational with the returning read data so the cache sees them at once.
  always_comb begin
    miss_ready  = 1'b0;
    busy        = 1'b0;
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    fill_we     = 1'b0;
    fill_addr   = '0;
    fill_data   = '0;
    crit_valid  = 1'b0;
    crit_data   = '0;
    fill_done   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        miss_ready = 1'b1;
      end
      ST_REQ: begin
        busy        = 1'b1;
        mem_rd_req  = 1'b1;
        mem_rd_addr = beat_addr_s;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (mem_rd_valid) begin
          fill_we   = 1'b1;
          fill_addr = beat_addr_s;
          fill_data = mem_rd_data;
          if (is_crit_s) begin
            crit_valid = 1'b1;
            crit_data  = mem_rd_data;
          end else begin
            crit_valid = 1'b0;
            crit_data  = '0;
          end
        end else begin
          fill_we    = 1'b0;
          crit_valid = 1'b0;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        fill_done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_refill_engine.sv
// Self-checking bench for cache_refill_engine. The bench plays the memory
// and the cache; expected read order, fill data, critical-word timing and
// fill_done cycle come from a reference model built on integer arithmetic.
module tb_cache_refill_engine;
  import cache_pkg::*;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int WPL = 4;

  logic          clk = 1'b0;
  logic          rsta;
  logic          miss_valid;
  logic          miss_ready;
  logic [AW-1:0] miss_addr;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_ack;
  logic          mem_rd_valid;
  logic [DW-1:0] mem_rd_data;
  logic          fill_we;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;
  logic          crit_valid;
  logic [DW-1:0] crit_data;
  logic          fill_done;
  logic          busy;

  int total    = 0;
  int bad      = 0;
  int fill_cnt = 0;
  int cyc      = 0;
  int done_cyc = -1;

  always #5 clk = ~clk;

  cache_refill_engine #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .WORDS_PER_LINE(WPL)
  ) dut (
    .clk         (clk),
    .rsta        (rsta),
    .miss_valid  (miss_valid),
    .miss_ready  (miss_ready),
    .miss_addr   (miss_addr),
    .mem_rd_req  (mem_rd_req),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_ack  (mem_rd_ack),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_data (mem_rd_data),
    .fill_we     (fill_we),
    .fill_addr   (fill_addr),
    .fill_data   (fill_data),
    .crit_valid  (crit_valid),
    .crit_data   (crit_data),
    .fill_done   (fill_done),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Memory contents: word at address a holds a*3+7.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    int v;
    v = int'(a) * 3 + 7;
    return DW'(v);
  endfunction

  // Reference read order for beat b of the refill of miss address m.
  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] m, input int b);
    int base, co, off;
    co   = int'(m) % WPL;
    base = int'(m) - co;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    off = (co + b) % WPL;
`else
    off = b;
`endif
    return AW'(base + off);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic observe();
    #1;
    if (fill_we === 1'b1) fill_cnt++;
    if (fill_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  endtask

  task automatic run_miss(input logic [AW-1:0] addr,
                          input int ack_min, input int ack_max,
                          input int val_min, input int val_max,
                          input bit stray, input bit hold, input int abort_fills);
    int d, v, fills, exp_done;
    bit got;
    logic [AW-1:0] a;
    got = 1'b0;
    for (int n = 0; n < 64 && !got; n++) begin
      miss_valid   = 1'b1;
      miss_addr    = addr;
      mem_rd_ack   = 1'b0;
      mem_rd_valid = stray ? 1'($urandom_range(1, 0)) : 1'b0;
      mem_rd_data  = $urandom;
      observe();
      if (miss_ready === 1'b1) begin
        got = 1'b1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_fill_we", fill_we, 1'b0);
        chk("idle_req", mem_rd_req, 1'b0);
      end
      tick();
    end
    chk("accept", got, 1'b1);
    if (!got) return;
    cyc        = 1;
    done_cyc   = -1;
    fills      = 0;
    exp_done   = 1;
    miss_valid = hold;
    for (int b = 0; b < WPL; b++) begin
      a = exp_addr(addr, b);
      d = $urandom_range(ack_max, ack_min);
      v = $urandom_range(val_max, val_min);
      exp_done += d + v + 2;
      for (int k = 0; k <= d; k++) begin
        mem_rd_ack   = (k == d);
        mem_rd_valid = stray ? 1'($urandom_range(1, 0)) : 1'b0;
        mem_rd_data  = $urandom;
        observe();
        chk("req", mem_rd_req, 1'b1);
        chk("req_addr", mem_rd_addr, a);
        chk("req_no_fill", fill_we, 1'b0);
        chk("req_busy", busy, 1'b1);
        chk("req_ready", miss_ready, 1'b0);
        chk("req_done", fill_done, 1'b0);
        tick();
      end
      for (int k = 0; k <= v; k++) begin
        mem_rd_ack   = 1'b0;
        mem_rd_valid = (k == v);
        mem_rd_data  = (k == v) ? mem_word(a) : DW'($urandom);
        observe();
        chk("wait_req", mem_rd_req, 1'b0);
        chk("fill_we", fill_we, mem_rd_valid);
        chk("wait_done", fill_done, 1'b0);
        if (k == v) begin
          chk("fill_addr", fill_addr, a);
          chk("fill_data", fill_data, mem_word(a));
          chk("crit_valid", crit_valid, (a == addr));
          if (a == addr) chk("crit_data", crit_data, mem_word(a));
          else chk("crit_data_idle", crit_data, '0);
        end else begin
          chk("crit_quiet", crit_valid, 1'b0);
        end
        tick();
      end
      fills++;
      if (abort_fills > 0 && fills == abort_fills) begin
        rsta         = 1'b0;
        miss_valid   = 1'b0;
        mem_rd_ack   = 1'b0;
        mem_rd_valid = 1'b0;
        #1;
        tick();
        rsta = 1'b1;
        for (int k = 0; k < 3; k++) begin
          mem_rd_ack   = 1'($urandom_range(1, 0));
          mem_rd_valid = 1'($urandom_range(1, 0));
          observe();
          chk("rst_busy", busy, 1'b0);
          chk("rst_ready", miss_ready, 1'b1);
          chk("rst_req", mem_rd_req, 1'b0);
          chk("rst_fill", fill_we, 1'b0);
          tick();
        end
        return;
      end
    end
    mem_rd_ack   = 1'b0;
    mem_rd_valid = 1'($urandom_range(1, 0));
    observe();
    chk("done_pulse", fill_done, 1'b1);
    chk("done_cycle", done_cyc, exp_done);
    chk("done_busy", busy, 1'b1);
    chk("done_no_fill", fill_we, 1'b0);
    tick();
    mem_rd_valid = 1'b0;
    observe();
    chk("post_ready", miss_ready, 1'b1);
    chk("post_busy", busy, 1'b0);
    chk("post_done", fill_done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0;
    rsta         = 1'b0;
    miss_valid   = 1'b1;
    miss_addr    = 12'h3C5;
    mem_rd_ack   = 1'b1;
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      observe();
      chk("rst_miss_ready", miss_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_req", mem_rd_req, 1'b0);
      chk("rst_mem_addr", mem_rd_addr, '0);
      chk("rst_fill_we", fill_we, 1'b0);
      chk("rst_fill_addr", fill_addr, '0);
      chk("rst_fill_data", fill_data, '0);
      chk("rst_crit", crit_valid, 1'b0);
      chk("rst_crit_data", crit_data, '0);
      chk("rst_done", fill_done, 1'b0);
      tick();
    end
    rsta         = 1'b1;
    miss_valid   = 1'b0;
    mem_rd_ack   = 1'b0;
    mem_rd_valid = 1'b0;
    tick();

    // Minimum-latency refill.
    run_miss(12'h00A, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    chk("min_latency", done_cyc, 9);
    // Line at the top of the address space.
    run_miss(12'hFFF, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    // Slow ack with stray valids during request.
    run_miss(12'h123, 3, 3, 0, 0, 1'b1, 1'b0, 0);
    chk("slow_latency", done_cyc, 21);
    // Reset after the second fill, then a fresh refill.
    run_miss(12'h05D, 0, 0, 0, 0, 1'b0, 1'b0, 2);
    run_miss(12'h010, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    // Back-to-back: request held through the first refill.
    f0 = fill_cnt;
    run_miss(12'h2A7, 0, 0, 0, 0, 1'b0, 1'b1, 0);
    run_miss(12'h2A7, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    chk("b2b_fills", fill_cnt - f0, 8);
    // Randomized refills.
    for (int i = 0; i < 20; i++) begin
      run_miss(AW'($urandom), 0, 3, 0, 3, 1'($urandom_range(1, 0)),
               (i < 19) ? 1'($urandom_range(1, 0)) : 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
